// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: default widths, PC increment and the fetch FSM state type.
package mips_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned PC_STEP        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/busca_saida_reg.sv
// Fetch output register: holds one instruction and its PC behind a valid/ready handshake,
// with a load port for new captures and a flush port that drops the pending entry.
module busca_saida_reg #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] word_q,  word_d;
  logic [ADDR_WIDTH-1:0] pc_q,    pc_d;

  // Flush beats load; data fields only change on a load so a stalled entry stays stable.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      word_d  = word_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction-fetch unit: PC register, IDLE/FETCH/HALT control and the decode-side output register.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (out-of-range fetch sets sticky fetch_error and halts).
module unidade_busca
  import mips_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           MEM_WORDS  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt_req,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  halted,
  output logic                  fetch_error
);

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(32'd3));

  if (MEM_WORDS == 0 || RESET_PC[1:0] != 2'b00) begin : g_bad_params
    $error("unidade_busca: MEM_WORDS must be nonzero and RESET_PC word aligned");
  end

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  load_s;
  logic                  flush_s;
  logic                  slot_free_s;
  logic                  out_valid_s;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_WORDS * 4);
  logic err_q, err_d;
  logic oob_s;
  assign oob_s = ({1'b0, pc_q} >= MEM_BYTES);
`endif

  assign slot_free_s = !out_valid_s || instr_ready;

  // Next-state, next-PC and output-register control, in halt > redirect > capture > stall order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load_s  = 1'b0;
    flush_s = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc & ALIGN_MASK;
          flush_s = 1'b1;
        end
`ifdef FETCH_BOUNDS_CHECK_EN
        else if (oob_s) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
`endif
        else if (slot_free_s) begin
          load_s = 1'b1;
          pc_d   = pc_q + STEP;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  // Sticky out-of-range flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign fetch_error = err_q;
`else
  assign fetch_error = 1'b0;
`endif

  busca_saida_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_saida (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_s),
    .flush_i (flush_s),
    .word_i  (mem_rdata),
    .pc_i    (pc_q),
    .ready_i (instr_ready),
    .valid_o (out_valid_s),
    .word_o  (instr_out),
    .pc_o    (instr_pc)
  );

  assign instr_valid = out_valid_s;
  assign mem_addr    = pc_q;
  assign halted      = (state_q == ST_HALT);

endmodule
